// File: rtl/montgomery_pkg.sv
// -----------------------------------------------------------------------------
// montgomery_pkg
// Shared definitions for the Montgomery datapath stages (mpadder, mp_cond_sub).
//   DEF_DATA_W      default operand/result width
//   DEF_ADDER_SIZE  default chunk width processed per cycle
//   state_t         FSM encoding shared by the chunked serial stages
//   calc_nchunk     chunk count derived from the two widths
//   calc_cnt_w      width of a counter that indexes those chunks
// -----------------------------------------------------------------------------
package montgomery_pkg;

  localparam int DEF_DATA_W     = 1028;
  localparam int DEF_ADDER_SIZE = 257;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SUB   = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int data_w, input int adder_size);
    return data_w / adder_size;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/mp_chunk_sub.sv
// -----------------------------------------------------------------------------
// mp_chunk_sub
// Combinational (ADDER_SIZE+1)-bit subtract with borrow: {borrow_out, diff} =
// a - b - borrow_in. This is the only arithmetic on the critical path of
// mp_cond_sub. Kept separate from mpadder's subtract chunk so both stages
// close timing independently.
//   a, b        ADDER_SIZE-bit unsigned operands
//   borrow_in   borrow from the previous (less significant) chunk
//   diff        ADDER_SIZE-bit difference
//   borrow_out  1 when a < b + borrow_in
// -----------------------------------------------------------------------------
module mp_chunk_sub #(
  parameter int ADDER_SIZE = 257
) (
  input  logic [ADDER_SIZE-1:0] a,
  input  logic [ADDER_SIZE-1:0] b,
  input  logic                  borrow_in,
  output logic [ADDER_SIZE-1:0] diff,
  output logic                  borrow_out
);

  logic [ADDER_SIZE:0] full;

  // One extra bit on top catches the borrow as the wrap-around sign bit.
  assign full       = {1'b0, a} - {1'b0, b} - {{ADDER_SIZE{1'b0}}, borrow_in};
  assign diff       = full[ADDER_SIZE-1:0];
  assign borrow_out = full[ADDER_SIZE];

endmodule

// File: rtl/mp_cond_sub.sv
// -----------------------------------------------------------------------------
// mp_cond_sub
// Final conditional subtraction after mpadder: given T < 2M, returns T mod M.
// T - M is formed serially one ADDER_SIZE-bit chunk per cycle; the last
// borrow decides whether T or T - M is presented. Same start/done handshake
// as mpadder so the two chain back to back.
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   start       one-cycle request, only looked at while idle
//   in_t        value to reduce (latched on acceptance)
//   in_m        modulus, zero-extended (latched on acceptance)
//   result      T mod M, registered, held until the next completion
//   done        one-cycle pulse when result/borrow_out are fresh
//   busy        high from acceptance until done rises
//   borrow_out  final borrow of T - M (1: T < M, T passed through)
// -----------------------------------------------------------------------------
module mp_cond_sub
  import montgomery_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDER_SIZE = DEF_ADDER_SIZE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_t,
  input  logic [DATA_W-1:0] in_m,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              borrow_out
);

  localparam int NCHUNK = calc_nchunk(DATA_W, ADDER_SIZE);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    borrow;
  logic [DATA_W-1:0]       t_reg;
  logic [DATA_W-1:0]       m_reg;
  logic [DATA_W-1:0]       d_reg;

  logic [ADDER_SIZE-1:0]   t_chunk;
  logic [ADDER_SIZE-1:0]   m_chunk;
  logic [ADDER_SIZE-1:0]   d_chunk;
  logic                    b_next;

  // Counter-indexed chunk select; no shifting of the operand registers.
  assign t_chunk = t_reg[int'(cnt) * ADDER_SIZE +: ADDER_SIZE];
  assign m_chunk = m_reg[int'(cnt) * ADDER_SIZE +: ADDER_SIZE];

  mp_chunk_sub #(
    .ADDER_SIZE (ADDER_SIZE)
  ) u_chunk_sub (
    .a          (t_chunk),
    .b          (m_chunk),
    .borrow_in  (borrow),
    .diff       (d_chunk),
    .borrow_out (b_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      borrow     <= 1'b0;
      t_reg      <= '0;
      m_reg      <= '0;
      d_reg      <= '0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Idle: accept a request and snapshot the operands.
        ST_IDLE: begin
          if (start) begin
            t_reg  <= in_t;
            m_reg  <= in_m;
            d_reg  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_SUB;
          end
        end

        // Serial subtract: one chunk per edge, borrow carried forward.
        ST_SUB: begin
          d_reg[int'(cnt) * ADDER_SIZE +: ADDER_SIZE] <= d_chunk;
          borrow <= b_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CHUNK) begin
            state <= ST_FINAL;
          end
        end

        // Select: a surviving borrow means T < M, so T is already reduced.
        ST_FINAL: begin
          result     <= borrow ? t_reg : d_reg;
          borrow_out <= borrow;
          done       <= 1'b1;
          busy       <= 1'b0;
          cnt        <= '0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_cond_sub.sv
// -----------------------------------------------------------------------------
// tb_mp_cond_sub
// Self-checking bench for mp_cond_sub at the default widths. Expected values
// come from a full-width reference: T >= M ? T - M : T, borrow = (T < M).
// -----------------------------------------------------------------------------
module tb_mp_cond_sub;

  localparam int W = 1028;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_t = '0;
  logic [W-1:0] in_m = '0;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         borrow_out;

  int n_checks = 0;
  int n_fail   = 0;

  mp_cond_sub dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_t       (in_t),
    .in_m       (in_m),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_wide();
    logic [1055:0] acc;
    acc = '0;
    for (int i = 0; i < 33; i++) acc = {acc[1023:0], 32'($urandom)};
    return acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] t, input logic [W-1:0] m);
    return (t >= m) ? t - m : t;
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] t, input logic [W-1:0] m);
    return (t < m);
  endfunction

  // Issues one request and waits (bounded) for done. Returns at the falling
  // edge where done is seen high. busy_ok clears if busy was low while waiting.
  // now=1 raises start on the current falling edge instead of the next one.
  task automatic do_op(input logic [W-1:0] t, input logic [W-1:0] m, input bit now,
                       output int edges, output bit busy_ok, output bit timed_out);
    if (!now) @(negedge clk);
    in_t  = t;
    in_m  = m;
    start = 1'b1;
    @(posedge clk);
    edges   = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_t  = rand_wide();
    in_m  = rand_wide();
    while (done !== 1'b1 && edges < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic check_op(input string name, input logic [W-1:0] t, input logic [W-1:0] m, input bit now);
    int edges; bit bok; bit to;
    logic [W-1:0] exp_r;
    exp_r = ref_result(t, m);
    do_op(t, m, now, edges, bok, to);
    n_checks++;
    if (to) begin
      n_fail++; $display("FAIL %s timeout: done not seen within 20 edges", name);
    end
    n_checks++;
    if (edges !== 5) begin
      n_fail++; $display("FAIL %s latency: got %0d edges, need 5", name, edges);
    end
    n_checks++;
    if (result !== exp_r) begin
      n_fail++; $display("FAIL %s result: got %h need %h", name, result, exp_r);
    end
    n_checks++;
    if (borrow_out !== ref_borrow(t, m)) begin
      n_fail++; $display("FAIL %s borrow_out: got %b need %b", name, borrow_out, ref_borrow(t, m));
    end
    n_checks++;
    if (!bok || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: during-ok %b, at done %b (need 1, 0)", name, bok, busy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: result=%h done=%b busy=%b borrow_out=%b need all 0",
                         result, done, busy, borrow_out);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] prev;
    check_op("basic_3000_1000", W'(3000), W'(1000), 1'b0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b one edge later, need 0", done);
    end
    // result must not move when a new request is accepted
    prev  = result;
    in_t  = W'(12345);
    in_m  = W'(6);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (result !== prev || busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_on_start: result=%h busy=%b need %h and 1", result, busy, prev);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_passthrough();
    check_op("lt_500_1000", W'(500), W'(1000), 1'b0);
    check_op("eq_1000_1000", W'(1000), W'(1000), 1'b0);
  endtask

  task automatic test_cross_chunk();
    logic [W-1:0] t;
    t = '0; t[257] = 1'b1;
    check_op("cross_2p257", t, W'(1), 1'b0);
    t = '0; t[771] = 1'b1;
    check_op("cross_2p771", t, W'(1), 1'b0);
  endtask

  task automatic test_full_width();
    logic [W-1:0] t, m, exp_r;
    int extra;
    t = rand_wide();
    t[W-1 -: 32] = 32'ha740f05c;
    t[7:0] = 8'h6e;
    m = t >> 1;
    exp_r = t - m;
    @(negedge clk);
    in_t = t; in_m = m; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      start = (j == 1 || j == 3 || j == 4);
      in_t  = W'(9);
      in_m  = W'(4);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || result !== exp_r || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL full_width: done=%b borrow=%b result=%h need done=1 borrow=0 result=%h",
                         done, borrow_out, result, exp_r);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0 || result !== exp_r) begin
      n_fail++; $display("FAIL start_ignored: %0d cycles with done/busy after completion, result=%h need 0 and %h",
                         extra, result, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first", W'(70), W'(40), 1'b0);
    check_op("b2b_second", W'(41), W'(50), 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    in_t = W'(3000); in_m = W'(1000); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || borrow_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: result=%h done=%b busy=%b borrow_out=%b need all 0",
                         result, done, busy, borrow_out);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_abandon: %0d cycles with done/busy after reset, need 0", seen);
    end
    check_op("after_reset_7_5", W'(7), W'(5), 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] m, r, t;
    for (int i = 0; i < 24; i++) begin
      m = rand_wide() >> $urandom_range(1, 1000);
      if (m == '0) m = W'(1);
      r = rand_wide() % m;
      case ($urandom_range(0, 3))
        0: t = r;
        1: t = m;
        default: t = m + r;
      endcase
      check_op($sformatf("random_%0d", i), t, m, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_passthrough();
    test_cross_chunk();
    test_full_width();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
